mmio_uart_bridge: RTL and testbench

- Sits directly downstream of the multicycle RISC-V core's single memory port, between the core and the unified instruction/data memory.
- Decodes the core address and passes ordinary accesses through to memory unchanged.
- Intercepts a two-word MMIO window that holds a UART transmitter: a TX data register backed by a small FIFO, and a status register.
- Gives the core a console output path without stalling it, because the core has no wait/ready input.

---
 rtl/riscv_mmio_pkg.sv | 21 ++
 rtl/uart_tx_serializer.sv | 140 ++++++++++++++
 rtl/mmio_uart_bridge.sv | 109 ++++++++++
 tb/tb_mmio_uart_bridge.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mmio_pkg.sv
// Shared addresses, status bit positions and TX FSM state encoding for the
// MMIO UART bridge.
package riscv_mmio_pkg;

  localparam logic [31:0] UART_TXDATA_ADDR = 32'h1001_0024;
  localparam logic [31:0] UART_STATUS_ADDR = UART_TXDATA_ADDR + 32'd4;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit FSM, baud down-counter and shifter; pulls bytes from the FIFO
// via valid/pop. Even parity bit is added when UART_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (0)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (UART_PARITY_EN builds only)
// STOP   | stop bit (1); chains straight into START if another byte waits
module uart_tx_serializer
  import riscv_mmio_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       pop,
  output logic       tx,
  output logic       busy
);

  localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);

  tx_state_e      state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic           tx_q, tx_d;
`ifdef UART_PARITY_EN
  logic           parity_q, parity_d;
`endif

  logic baud_zero;
  assign baud_zero = (baud_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
`ifdef UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
`ifdef UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = (state_q == IDLE) ? '0 : baud_q - BW'(1);
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
`ifdef UART_PARITY_EN
    parity_d  = parity_q;
`endif
    // pop is asserted only from IDLE or the last STOP cycle; both load a new frame
    if (pop) begin
      state_d = START;
      shift_d = data;
      tx_d    = 1'b0;
      baud_d  = BAUD_LOAD;
`ifdef UART_PARITY_EN
      parity_d = ^data;
`endif
    end else begin
      case (state_q)
        IDLE: tx_d = 1'b1;
        START: begin
          if (baud_zero) begin
            state_d   = DATA;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = 3'd0;
            baud_d    = BAUD_LOAD;
          end
        end
        DATA: begin
          if (baud_zero) begin
            baud_d = BAUD_LOAD;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
              state_d = PARITY;
              tx_d    = parity_q;
`else
              state_d = STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
              tx_d      = shift_q[0];
              shift_d   = {1'b0, shift_q[7:1]};
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (baud_zero) begin
            state_d = STOP;
            tx_d    = 1'b1;
            baud_d  = BAUD_LOAD;
          end
        end
`endif
        STOP: begin
          if (baud_zero) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            baud_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
          baud_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    pop  = valid & ((state_q == IDLE) | ((state_q == STOP) & baud_zero));
    busy = (state_q != IDLE);
    tx   = tx_q;
  end

endmodule

// File: rtl/mmio_uart_bridge.sv
// Memory-port bridge: passes core accesses to memory and intercepts the
// TXDATA/STATUS MMIO words of a FIFO-fed UART transmitter (UART_PARITY_EN adds parity).
module mmio_uart_bridge
  import riscv_mmio_pkg::*;
#(
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] UART_BASE  = UART_TXDATA_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] core_adr,
  input  logic        core_we,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic [31:0] mem_adr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        uart_tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [7:0]    fifo_mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic hit_tx, hit_st;
  logic fifo_full, fifo_empty;
  logic push_req, push, pop, tx_busy;
  logic [3:0] status;

  assign hit_tx     = (core_adr == UART_BASE);
  assign hit_st     = (core_adr == UART_BASE + 32'd4);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  assign mem_adr   = core_adr;
  assign mem_wdata = core_wdata;
  assign mem_we    = core_we & ~(hit_tx | hit_st);

  always_comb begin
    status           = '0;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_BUSY]  = tx_busy;
    status[ST_OVF]   = ovf_q;
    if (hit_st)      core_rdata = {28'b0, status};
    else if (hit_tx) core_rdata = 32'b0;
    else             core_rdata = mem_rdata;
  end

  // A full FIFO still accepts a push when the serializer pops on the same edge.
  always_comb begin
    push_req = core_we & hit_tx;
    push     = push_req & (~fifo_full | pop);

    fifo_mem_d = fifo_mem_q;
    if (push) fifo_mem_d[wr_ptr_q] = core_wdata[7:0];
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q;
    if (core_we & hit_st & core_wdata[ST_OVF]) ovf_d = 1'b0;
    if (push_req & ~push)                      ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  uart_tx_serializer #(
    .CLK_DIV (CLK_DIV)
  ) u_ser (
    .clk   (clk),
    .rst   (rst),
    .valid (~fifo_empty),
    .data  (fifo_mem_q[rd_ptr_q]),
    .pop   (pop),
    .tx    (uart_tx),
    .busy  (tx_busy)
  );

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Directed bench for mmio_uart_bridge with CLK_DIV=4, FIFO_DEPTH=4.
module tb_mmio_uart_bridge;

  localparam logic [31:0] TXA = 32'h1001_0024;
  localparam logic [31:0] STA = 32'h1001_0028;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk, rst;
  logic [31:0] core_adr, core_wdata, core_rdata;
  logic        core_we;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic        mem_we, uart_tx;

  int tests = 0;
  int fails = 0;

  mmio_uart_bridge #(
    .CLK_DIV    (4),
    .FIFO_DEPTH (4),
    .UART_BASE  (32'h1001_0024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_adr   (core_adr),
    .core_we    (core_we),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .mem_adr    (mem_adr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .uart_tx    (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic        exp_we;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  // Samples uart_tx once per cycle starting after `skip` cycles of the frame.
  task automatic expect_frame(input logic [10:0] fb, input int nb, input int skip,
                              input bit chk_st, input logic [31:0] st_mid);
    logic [10:0] bits;
    bits = fb;
    for (int s = skip; s < nb * 4; s++) begin
      @(negedge clk);
      chk("frame_bit", {31'b0, uart_tx}, {31'b0, bits[s/4]});
      if (chk_st && s == 20) chk("status_mid", core_rdata, st_mid);
    end
  endtask

  task automatic go_idle();
    core_we    = 1'b0;
    core_adr   = 32'h0000_0040;
    core_wdata = 32'h0;
    mem_rdata  = 32'h0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0040, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[1] = '{32'h0000_0040, 1'b0, 32'h0000_0000, 32'h0000_1234, 1'b0, 32'h0000_1234};
    vecs[2] = '{32'h1001_0024, 1'b1, 32'h0000_00A5, 32'h0000_FFFF, 1'b0, 32'h0000_0000};
    vecs[3] = '{32'h1001_0028, 1'b0, 32'h0000_0000, 32'h0000_FFFF, 1'b0, 32'h0000_0002};
    vecs[4] = '{32'h1001_0028, 1'b1, 32'h0000_0008, 32'h0000_FFFF, 1'b0, 32'h0000_0002};
    vecs[5] = '{32'h1001_0020, 1'b1, 32'h1111_2222, 32'h0000_0055, 1'b1, 32'h0000_0055};
    vecs[6] = '{32'h1001_002C, 1'b0, 32'h0000_0000, 32'h0000_ABCD, 1'b0, 32'h0000_ABCD};
    vecs[7] = '{32'h1001_0025, 1'b1, 32'h0000_0077, 32'h8000_0001, 1'b1, 32'h8000_0001};

    go_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    core_adr = STA;
    #1;
    chk("reset_tx", {31'b0, uart_tx}, 32'h1);
    chk("reset_status", core_rdata, 32'h2);
    rst = 1'b0;
    go_idle();

    // Combinational decode; write strobes are dropped before the edge.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      core_adr   = vecs[i].adr;
      core_we    = vecs[i].we;
      core_wdata = vecs[i].wdata;
      mem_rdata  = vecs[i].mrd;
      #1;
      chk("vec_mem_we", {31'b0, mem_we}, {31'b0, vecs[i].exp_we});
      chk("vec_rdata", core_rdata, vecs[i].exp_rd);
      chk("vec_mem_adr", mem_adr, vecs[i].adr);
      chk("vec_mem_wdata", mem_wdata, vecs[i].wdata);
      chk("vec_tx_idle", {31'b0, uart_tx}, 32'h1);
      #1;
      core_we = 1'b0;
    end
    go_idle();

    // Single byte 0xA5
    @(negedge clk);
    core_adr = TXA; core_we = 1'b1; core_wdata = 32'h0000_00A5;
    #1;
    chk("single_mem_we", {31'b0, mem_we}, 32'h0);
    @(negedge clk);
    core_we = 1'b0; core_adr = STA;
    #1;
    chk("single_tx_pre", {31'b0, uart_tx}, 32'h1);
    chk("single_status_queued", core_rdata, 32'h0);
    expect_frame(frame_of(8'hA5), NB, 0, 1'b1, 32'h6);
    @(negedge clk);
    chk("single_status_after", core_rdata, 32'h2);
    chk("single_tx_after", {31'b0, uart_tx}, 32'h1);

    // Overflow: six back-to-back stores
    for (int b = 1; b <= 6; b++) begin
      core_adr = TXA; core_we = 1'b1; core_wdata = b;
      @(negedge clk);
    end
    core_we = 1'b0; core_adr = STA;
    #1;
    chk("ovf_status", core_rdata, 32'hD);
    core_we = 1'b1; core_wdata = 32'h8;
    @(negedge clk);
    core_we = 1'b0;
    #1;
    chk("ovf_clear_status", core_rdata, 32'h5);
    expect_frame(frame_of(8'h01), NB, 6, 1'b0, 32'h0);
    for (int b = 2; b <= 5; b++)
      expect_frame(frame_of(8'(b)), NB, 0, (b == 5), 32'h6);
    @(negedge clk);
    chk("ovf_status_end", core_rdata, 32'h2);
    chk("ovf_tx_end", {31'b0, uart_tx}, 32'h1);

    // Push landing on the STOP->START pop edge while full
    for (int b = 8'h11; b <= 8'h15; b++) begin
      core_adr = TXA; core_we = 1'b1; core_wdata = b;
      @(negedge clk);
    end
    core_we = 1'b0; core_adr = STA;
    #1;
    chk("simul_full_status", core_rdata, 32'h5);
    expect_frame(frame_of(8'h11), NB, 4, 1'b0, 32'h0);
    core_adr = TXA; core_we = 1'b1; core_wdata = 32'hFFFF_FF16;
    @(negedge clk);
    core_we = 1'b0; core_adr = STA;
    #1;
    chk("simul_status", core_rdata, 32'h5);
    expect_frame(frame_of(8'h12), NB, 1, 1'b0, 32'h0);
    for (int b = 8'h13; b <= 8'h16; b++)
      expect_frame(frame_of(8'(b)), NB, 0, (b == 8'h16), 32'h6);
    @(negedge clk);
    chk("simul_status_end", core_rdata, 32'h2);

    // Reset during data bit 3 of 0xC3 with two bytes queued
    for (int b = 0; b < 3; b++) begin
      core_adr = TXA; core_we = 1'b1;
      core_wdata = (b == 0) ? 32'hC3 : ((b == 1) ? 32'h5A : 32'h66);
      @(negedge clk);
    end
    core_we = 1'b0; core_adr = STA;
    for (int s = 2; s < 17; s++) begin
      logic [10:0] fc;
      fc = frame_of(8'hC3);
      @(negedge clk);
      chk("rst_pre_bit", {31'b0, uart_tx}, {31'b0, fc[s/4]});
    end
    chk("rst_bit3_low", {31'b0, uart_tx}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_tx", {31'b0, uart_tx}, 32'h1);
    chk("rst_status", core_rdata, 32'h2);
    for (int s = 0; s < 60; s++) begin
      @(negedge clk);
      chk("rst_line_quiet", {31'b0, uart_tx}, 32'h1);
    end
    chk("rst_status_later", core_rdata, 32'h2);

    // Hand-built frames for 0x07 and 0x03
    for (int k = 0; k < 2; k++) begin
      logic [10:0] hand;
      core_adr = TXA; core_we = 1'b1; core_wdata = (k == 0) ? 32'h07 : 32'h03;
      @(negedge clk);
      core_we = 1'b0; core_adr = STA;
`ifdef UART_PARITY_EN
      hand = (k == 0) ? 11'b1_1_00000111_0 : 11'b1_0_00000011_0;
      expect_frame(hand, 11, 0, 1'b0, 32'h0);
`else
      hand = (k == 0) ? 11'b1_1_00000111_0 : 11'b1_1_00000011_0;
      expect_frame(hand, 10, 0, 1'b0, 32'h0);
`endif
      @(negedge clk);
      chk("hand_idle", core_rdata, 32'h2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
